// File: rtl/vecram_arbiter.sv
// vecram_arbiter: shares one single-port 8Kx8 vector RAM between the 6502 bus
// and the AVG instruction fetch. CPU accesses take 2 cycles, AVG fetches
// 3 cycles (two byte reads assembled into a 16-bit word). The CPU has
// priority at every grant point, but an AVG fetch in progress always
// completes first.
// Ports: clk/rst (sync, active-high); cpu_req/cpu_we/cpu_addr/cpu_wdata in,
//        cpu_rdata/cpu_done out; avg_fetch/avg_pc in, inst/inst_valid out;
//        ram_addr/ram_we/ram_wdata out, ram_rdata in (1-cycle read latency).
module vecram_arbiter #(
  parameter int          ADDR_W  = 13,
  parameter logic [15:0] PC_BASE = 16'h2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_done,
  input  logic              avg_fetch,
  input  logic [15:0]       avg_pc,
  output logic [15:0]       inst,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  typedef enum logic [2:0] {
    IDLE, CPU_ACC, CPU_DATA, AVG_HI, AVG_LO, AVG_CAP
  } state_t;

  state_t state, state_nxt;

  // Pending (one-entry, last wins) request latches.
  logic              cpu_pend;
  logic              pend_we;
  logic [ADDR_W-1:0] pend_addr;
  logic [7:0]        pend_wdata;
  logic              avg_pend;
  logic [ADDR_W-2:0] pend_word;

  // Request currently in service; kept separate from the pending latch so a
  // new strobe during service cannot disturb the access in flight.
  logic              svc_we;
  logic [ADDR_W-1:0] svc_addr;
  logic [7:0]        svc_wdata;
  logic [ADDR_W-2:0] svc_word;

  logic [7:0]        hi_byte;
  logic [ADDR_W-1:0] addr_hold;

  // Truncated subtraction only needs the low ADDR_W bits of each operand.
  logic [ADDR_W-1:0] fetch_a;
  logic [ADDR_W-2:0] fetch_word;
  logic              unused_bits;

  assign fetch_a     = avg_pc[ADDR_W-1:0] - PC_BASE[ADDR_W-1:0];
  assign fetch_word  = fetch_a[ADDR_W-1:1];
  assign unused_bits = ^{avg_pc[15:ADDR_W], fetch_a[0]};

  // A strobe in the current cycle counts as pending, so a request from IDLE
  // is granted at the very edge that samples it.
  logic cpu_want, avg_want, cpu_grant, avg_grant;
  assign cpu_want = cpu_pend | cpu_req;
  assign avg_want = avg_pend | avg_fetch;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cpu_want)      state_nxt = CPU_ACC;
        else if (avg_want) state_nxt = AVG_HI;
      end
      CPU_ACC: state_nxt = CPU_DATA;
      AVG_HI:  state_nxt = AVG_LO;
      AVG_LO:  state_nxt = AVG_CAP;
      CPU_DATA, AVG_CAP: begin
        if (cpu_want)      state_nxt = CPU_ACC;
        else if (avg_want) state_nxt = AVG_HI;
        else               state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Every entry into CPU_ACC / AVG_HI is a grant.
  assign cpu_grant = (state_nxt == CPU_ACC);
  assign avg_grant = (state_nxt == AVG_HI);

  always_comb begin
    ram_addr = addr_hold;
    ram_we   = 1'b0;
    case (state)
      CPU_ACC: begin
        ram_addr = svc_addr;
        // rst gating aborts a write that is in flight when reset arrives.
        ram_we   = svc_we & ~rst;
      end
      AVG_HI:  ram_addr = {svc_word, 1'b0};
      AVG_LO:  ram_addr = {svc_word, 1'b1};
      default: ram_addr = addr_hold;
    endcase
  end

  assign ram_wdata = svc_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cpu_pend   <= 1'b0;
      pend_we    <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
      avg_pend   <= 1'b0;
      pend_word  <= '0;
      svc_we     <= 1'b0;
      svc_addr   <= '0;
      svc_wdata  <= '0;
      svc_word   <= '0;
      hi_byte    <= '0;
      addr_hold  <= '0;
      cpu_rdata  <= '0;
      cpu_done   <= 1'b0;
      inst       <= '0;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr_hold  <= ram_addr;
      cpu_done   <= (state == CPU_DATA);
      inst_valid <= (state == AVG_CAP);

      if (state == CPU_DATA && !svc_we) cpu_rdata <= ram_rdata;
      if (state == AVG_LO)              hi_byte   <= ram_rdata;
      if (state == AVG_CAP)             inst      <= {hi_byte, ram_rdata};

      if (cpu_req) begin
        pend_we    <= cpu_we;
        pend_addr  <= cpu_addr;
        pend_wdata <= cpu_wdata;
      end
      if (cpu_grant) begin
        cpu_pend  <= 1'b0;
        svc_we    <= cpu_req ? cpu_we    : pend_we;
        svc_addr  <= cpu_req ? cpu_addr  : pend_addr;
        svc_wdata <= cpu_req ? cpu_wdata : pend_wdata;
      end else if (cpu_req) begin
        cpu_pend <= 1'b1;
      end

      if (avg_fetch) pend_word <= fetch_word;
      if (avg_grant) begin
        avg_pend <= 1'b0;
        svc_word <= avg_fetch ? fetch_word : pend_word;
      end else if (avg_fetch) begin
        avg_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vecram_arbiter.sv
module tb_vecram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_done;
  logic        avg_fetch;
  logic [15:0] avg_pc, inst;
  logic        inst_valid;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata, ram_rdata;

  vecram_arbiter #(.ADDR_W(13), .PC_BASE(16'h2000)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .avg_fetch(avg_fetch), .avg_pc(avg_pc), .inst(inst), .inst_valid(inst_valid),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM, synchronous read.
  logic [7:0] mem [0:8191];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log, sampled mid-cycle.
  int         we_cnt, we_cyc, done_cnt, done_cyc, iv_cnt, iv_cyc;
  logic [12:0] we_addr;
  logic [7:0]  we_data, done_data;
  logic [15:0] iv_data;

  always @(negedge clk) begin
    if (ram_we)     begin we_cnt++;   we_cyc = cyc;   we_addr = ram_addr; we_data = ram_wdata; end
    if (cpu_done)   begin done_cnt++; done_cyc = cyc; done_data = cpu_rdata; end
    if (inst_valid) begin iv_cnt++;   iv_cyc = cyc;   iv_data = inst; end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    we_cnt = 0; done_cnt = 0; iv_cnt = 0;
    we_cyc = -100; done_cyc = -100; iv_cyc = -100;
  endtask

  int t, tc;

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    avg_fetch = 1'b0; avg_pc = '0;
    clear_log();

    // Reset: a write strobe during reset must be discarded.
    step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0123; cpu_wdata = 8'h5A;
    step();
    cpu_req = 1'b0;
    step(); step();
    @(negedge clk);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
    check("rst_cpu_done", 32'(cpu_done), 32'h0);
    check("rst_inst", 32'(inst), 32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    step();
    rst = 1'b0;
    repeat (6) step();
    check("rst_no_write", 32'(we_cnt), 32'd0);
    check("rst_no_done", 32'(done_cnt), 32'd0);
    check("rst_mem_untouched", 32'(mem[13'h0123]), 32'h00);

    // CPU write 0xA5 to 0x0123.
    clear_log();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0123; cpu_wdata = 8'hA5; t = cyc;
    step();
    cpu_req = 1'b0;
    repeat (8) step();
    check("wr_we_count", 32'(we_cnt), 32'd1);
    check("wr_we_latency", 32'(we_cyc - t), 32'd1);
    check("wr_we_addr", 32'(we_addr), 32'h0123);
    check("wr_we_data", 32'(we_data), 32'hA5);
    check("wr_done_latency", 32'(done_cyc - t), 32'd3);
    check("wr_done_count", 32'(done_cnt), 32'd1);
    check("wr_mem", 32'(mem[13'h0123]), 32'hA5);

    // CPU read back 0x0123.
    clear_log();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123; t = cyc;
    step();
    cpu_req = 1'b0;
    repeat (8) step();
    check("rd_done_latency", 32'(done_cyc - t), 32'd3);
    check("rd_data_at_done", 32'(done_data), 32'hA5);
    check("rd_data_held", 32'(cpu_rdata), 32'hA5);
    check("rd_no_write", 32'(we_cnt), 32'd0);

    // AVG fetch with odd PC, aligned down.
    mem[13'h0040] = 8'h12;
    mem[13'h0041] = 8'h34;
    clear_log();
    avg_fetch = 1'b1; avg_pc = 16'h2041; t = cyc;
    step();
    avg_fetch = 1'b0;
    repeat (8) step();
    check("avg_valid_count", 32'(iv_cnt), 32'd1);
    check("avg_valid_latency", 32'(iv_cyc - t), 32'd4);
    check("avg_inst", 32'(iv_data), 32'h1234);
    check("avg_inst_held", 32'(inst), 32'h1234);
    check("avg_addr_hold", 32'(ram_addr), 32'h0041);

    // Collision: CPU write and AVG fetch of the same word in one cycle.
    clear_log();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0040; cpu_wdata = 8'h77;
    avg_fetch = 1'b1; avg_pc = 16'h2040; t = cyc;
    step();
    cpu_req = 1'b0; avg_fetch = 1'b0;
    repeat (10) step();
    check("col_done_latency", 32'(done_cyc - t), 32'd3);
    check("col_valid_latency", 32'(iv_cyc - t), 32'd6);
    check("col_inst", 32'(iv_data), 32'h7734);
    check("col_we_count", 32'(we_cnt), 32'd1);

    // Preemption: CPU read one cycle after AVG_HI begins.
    clear_log();
    avg_fetch = 1'b1; avg_pc = 16'h2040; t = cyc;
    step();
    avg_fetch = 1'b0;
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0041; tc = cyc;
    step();
    cpu_req = 1'b0;
    repeat (10) step();
    check("pre_valid_latency", 32'(iv_cyc - t), 32'd4);
    check("pre_inst", 32'(iv_data), 32'h7734);
    check("pre_done_latency", 32'(done_cyc - tc), 32'd4);
    check("pre_rdata", 32'(done_data), 32'h34);

    // Worst case: CPU strobe during AVG_HI itself.
    clear_log();
    avg_fetch = 1'b1; avg_pc = 16'h2040; t = cyc;
    step();
    avg_fetch = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0040; tc = cyc;
    step();
    cpu_req = 1'b0;
    repeat (10) step();
    check("worst_valid_latency", 32'(iv_cyc - t), 32'd4);
    check("worst_done_latency", 32'(done_cyc - tc), 32'd5);
    check("worst_rdata", 32'(done_data), 32'h77);

    // Reset during AVG_LO aborts the fetch.
    clear_log();
    avg_fetch = 1'b1; avg_pc = 16'h2041; t = cyc;
    step();
    avg_fetch = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_inst_cleared", 32'(inst), 32'h0);
    repeat (6) step();
    check("midrst_no_valid", 32'(iv_cnt), 32'd0);
    check("midrst_cpu_rdata_cleared", 32'(cpu_rdata), 32'h0);

    clear_log();
    avg_fetch = 1'b1; avg_pc = 16'h2040; t = cyc;
    step();
    avg_fetch = 1'b0;
    repeat (8) step();
    check("after_rst_valid_latency", 32'(iv_cyc - t), 32'd4);
    check("after_rst_inst", 32'(iv_data), 32'h7734);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vecram_arbiter.md
# vecram_arbiter

Time-multiplexes a single-port 8 Kx8 vector RAM between two requesters. The first is the 6502 bus, for writes and readback in the `$2000–$3FFF` window. The second is the AVG instruction fetch, which needs 16-bit words assembled from two byte reads. The block replaces the duplicated vector-RAM copies with one shared store. It sits between the address decoder / `avg_core` and the RAM. CPU requests have strict priority and complete well inside one 3 MHz CPU slot, which is 8 clk cycles.

## Interface
Parameters:
- ADDR_W, 13, vector RAM byte-address width
- PC_BASE, 16'h2000, subtracted from avg_pc to form the RAM address

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  one-cycle request strobe
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req
- cpu_addr  in  ADDR_W  byte address; sampled with cpu_req
- cpu_wdata  in  8  write data; sampled with cpu_req
- cpu_rdata  out  8  read data; valid when cpu_done = 1, held until the next CPU read completes
- cpu_done  out  1  one-cycle completion pulse, for reads and writes
- avg_fetch  in  1  one-cycle fetch strobe
- avg_pc  in  16  AVG program counter; sampled with avg_fetch
- inst  out  16  fetched instruction word; held until the next fetch completes
- inst_valid  out  1  one-cycle pulse when inst is updated
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM read data; 1-cycle synchronous read latency

## Operation
- **Request latches.** Each requester has a one-entry pending latch.
  - Set by its strobe; cleared when that request enters service.
  - A strobe while the latch is already pending overwrites it (last wins).
  - A strobe arriving while the same requester is in service becomes the new pending entry.
- **FSM states:** IDLE, CPU_ACC, CPU_DATA, AVG_HI, AVG_LO, AVG_CAP.
- **IDLE:**
  - CPU pending → CPU_ACC.
  - Otherwise, AVG pending → AVG_HI.
  - Otherwise stay in IDLE.
- **CPU_ACC:**
  - ram_addr = latched cpu_addr.
  - For a write: ram_we = 1, ram_wdata = latched cpu_wdata.
  - Next state is CPU_DATA.
- **CPU_DATA:**
  - For a read, cpu_rdata is registered from ram_rdata at the end of this cycle.
  - cpu_done is registered high for the following cycle.
  - Next state: CPU_ACC if CPU is pending again, else AVG_HI if AVG is pending, else IDLE.
- **AVG address:** a = avg_pc − PC_BASE, truncated to ADDR_W bits.
  - Even byte {a[12:1],0} is the instruction high byte; odd byte {a[12:1],1} is the low byte.
  - Bit 0 of a is ignored.
- **AVG_HI:** drives the even address; next state AVG_LO.
- **AVG_LO:**
  - Drives the odd address.
  - Captures ram_rdata into a staging register as the high byte.
  - Next state AVG_CAP.
- **AVG_CAP:**
  - inst is registered as {high byte, ram_rdata} at the end of the cycle, and inst_valid pulses the following cycle.
  - Next state: CPU_ACC if CPU is pending, else AVG_HI if AVG is pending, else IDLE.
- **Preemption.** The AVG 2-byte sequence is never interrupted; the CPU waits at most until AVG_CAP completes.
- **Idle bus.** In states with no access, ram_we = 0 and ram_addr holds its last value.
- **Ordering.** Accesses are strictly serialised. A CPU write followed by an AVG fetch of the same word returns the new data.
- **Reset:**
  - State returns to IDLE and both pending latches clear.
  - cpu_rdata, inst and the staging register go to 0.
  - cpu_done, inst_valid and ram_we go to 0.
  - An access in flight is aborted, with no write and no done/valid pulse.
  - Strobes sampled while rst = 1 are discarded.

## Timing
- **CPU from IDLE** (strobe sampled at edge of cycle t):
  - CPU_ACC in t+1, CPU_DATA in t+2.
  - cpu_done = 1 and cpu_rdata valid in t+3.
- **CPU worst case:** strobe arrives just after AVG_HI begins. AVG_LO and AVG_CAP finish first, so cpu_done lands at t+5. This is within the 8-cycle CPU slot.
- **AVG from IDLE** (strobe at t): AVG_HI t+1, AVG_LO t+2, AVG_CAP t+3; inst_valid = 1 in t+4.
- **Simultaneous strobes in the same cycle:** CPU first, then AVG back-to-back.
  - cpu_done at t+3.
  - AVG_HI at t+3, inst_valid at t+6.
- **Throughput and starvation:** 2 cycles per CPU access, 3 per AVG fetch, no idle cycle between back-to-back grants. The CPU issues at most one request per 8 cycles, so AVG starvation is bounded to 2 cycles per CPU slot.

## Test plan
- **Reset values:** hold rst 3 cycles → all outputs 0, then IDLE. Issue a cpu_req write with rst = 1 → ram_we never asserts.
- **CPU write/read:**
  - Write 8'hA5 at 13'h0123; expect ram_we = 1 in t+1 with ram_addr = 13'h0123, and cpu_done at t+3.
  - Read 13'h0123; expect cpu_rdata = 8'hA5 with cpu_done at t+3.
- **AVG fetch:** RAM holds [0x0040] = 8'h12 and [0x0041] = 8'h34. Fetch with avg_pc = 16'h2041 → inst = 16'h1234, inst_valid at t+4; the odd PC is aligned down.
- **Collision:** cpu_req write 8'h77 to 13'h0040 in the same cycle as avg_fetch with avg_pc = 16'h2040 → write completes first (cpu_done t+3), then inst = 16'h7734 with inst_valid at t+6.
- **Preemption bound:** cpu_req one cycle after AVG_HI begins → AVG completes uninterrupted, and cpu_done arrives ≤ 5 cycles after the strobe.
- **Reset mid-fetch:** assert rst during AVG_LO → no inst_valid, inst = 0, next avg_fetch behaves as from IDLE.
